i2s_apb_seq: RTL

I2S_APB_SEQ -- requirements
Module: i2s_apb_seq

---
 rtl/i2s_apb_seq.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/i2s_apb_seq.sv
// rtl/i2s_apb_seq.sv - APB access sequencer for an I2S transceiver (optional Rx path: I2S_SEQ_RX_EN)
module i2s_apb_seq #(
  parameter int PRELOAD     = 4,
  parameter int TRAN_EN_BIT = 0
) (
  input  logic        pclk,
  input  logic        preset,
  input  logic        start,
  input  logic        stop,
  input  logic [31:0] cfg_word,
  input  logic [31:0] tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic [31:0] rx_data,
  output logic        rx_valid,
  input  logic        i2s_tx_full,
  input  logic        i2s_rx_empty,
  output logic [31:0] paddr,
  output logic [31:0] pwdata,
  output logic        pwrite,
  output logic        penable,
  input  logic [31:0] prdata,
  output logic        busy
);

  localparam logic [31:0] EN_MASK   = 32'd1 << TRAN_EN_BIT;
  localparam logic [3:0]  PRE_N     = 4'(PRELOAD);
  localparam logic [31:0] ADDR_CTRL = 32'h0;
  localparam logic [31:0] ADDR_TX   = 32'h4;
  localparam logic [31:0] ADDR_RX   = 32'h8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CFG,
    ST_PRELOAD,
    ST_ENABLE,
    ST_RUN,
    ST_DISABLE
  } state_t;

  // All APB outputs are registered: the access visible in a cycle is the
  // action of the state held in that cycle, decided at the edge entering it
  // from the inputs sampled there. tx_ready therefore marks the cycle in
  // which the word sampled at the preceding edge is written to the Tx port.
  state_t      state;
  logic [3:0]  pre_cnt;
  logic [31:0] cfg_q;
  logic        rr_rx;
  logic        tx_elig;
  logic        rx_elig;
  logic        rr_eff;
  logic        grant_tx;
  logic        grant_rx;

  assign tx_elig = tx_valid & ~i2s_tx_full;

`ifdef I2S_SEQ_RX_EN
  assign rx_elig = ~i2s_rx_empty;
`else
  logic unused_rx;
  assign rx_elig   = 1'b0;
  assign unused_rx = ^{prdata, i2s_rx_empty};
`endif

  // Round-robin arbitration between Tx write and Rx read; Tx wins first after entry to RUN
  always_comb begin
    rr_eff   = (state == ST_ENABLE) ? 1'b0 : rr_rx;
    grant_tx = 1'b0;
    grant_rx = 1'b0;
    if (tx_elig && rx_elig) begin
      grant_rx = rr_eff;
      grant_tx = ~rr_eff;
    end else begin
      grant_tx = tx_elig;
      grant_rx = rx_elig;
    end
  end

  // Sequencer FSM with registered APB, handshake and status outputs
  always_ff @(posedge pclk) begin
    if (preset) begin
      state    <= ST_IDLE;
      pre_cnt  <= 4'd0;
      cfg_q    <= 32'd0;
      rr_rx    <= 1'b0;
      paddr    <= 32'd0;
      pwdata   <= 32'd0;
      pwrite   <= 1'b0;
      penable  <= 1'b0;
      tx_ready <= 1'b0;
      rx_data  <= 32'd0;
      rx_valid <= 1'b0;
      busy     <= 1'b0;
    end else begin
      penable  <= 1'b0;
      pwrite   <= 1'b0;
      tx_ready <= 1'b0;
      rx_valid <= 1'b0;
`ifdef I2S_SEQ_RX_EN
      // A read was on the bus this cycle; hand its data to the requester next cycle
      if (penable && !pwrite) begin
        rx_data  <= prdata;
        rx_valid <= 1'b1;
      end
`endif
      if (stop && (state != ST_IDLE) && (state != ST_DISABLE)) begin
        state   <= ST_DISABLE;
        penable <= 1'b1;
        pwrite  <= 1'b1;
        paddr   <= ADDR_CTRL;
        pwdata  <= cfg_q & ~EN_MASK;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start && !stop) begin
              state   <= ST_CFG;
              busy    <= 1'b1;
              cfg_q   <= cfg_word & ~EN_MASK;
              pre_cnt <= 4'd0;
              penable <= 1'b1;
              pwrite  <= 1'b1;
              paddr   <= ADDR_CTRL;
              pwdata  <= cfg_word & ~EN_MASK;
            end
          end
          ST_CFG: begin
            state <= ST_PRELOAD;
            if (tx_elig) begin
              penable  <= 1'b1;
              pwrite   <= 1'b1;
              paddr    <= ADDR_TX;
              pwdata   <= tx_data;
              tx_ready <= 1'b1;
              pre_cnt  <= 4'd1;
            end
          end
          ST_PRELOAD: begin
            if ((pre_cnt >= PRE_N) || i2s_tx_full) begin
              state   <= ST_ENABLE;
              penable <= 1'b1;
              pwrite  <= 1'b1;
              paddr   <= ADDR_CTRL;
              pwdata  <= cfg_q | EN_MASK;
            end else if (tx_elig) begin
              penable  <= 1'b1;
              pwrite   <= 1'b1;
              paddr    <= ADDR_TX;
              pwdata   <= tx_data;
              tx_ready <= 1'b1;
              pre_cnt  <= pre_cnt + 4'd1;
            end
          end
          ST_ENABLE, ST_RUN: begin
            state <= ST_RUN;
            rr_rx <= rr_eff;
            if (grant_tx) begin
              penable  <= 1'b1;
              pwrite   <= 1'b1;
              paddr    <= ADDR_TX;
              pwdata   <= tx_data;
              tx_ready <= 1'b1;
              rr_rx    <= 1'b1;
            end else if (grant_rx) begin
              penable <= 1'b1;
              pwrite  <= 1'b0;
              paddr   <= ADDR_RX;
              rr_rx   <= 1'b0;
            end
          end
          ST_DISABLE: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
